conv_frame_sequencer: RTL and testbench

//  Frame controller for the 8-tap circular convolution engine. Accepts one frame of 16

---
 rtl/conv_frame_sequencer.sv | 153 +++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_sequencer.sv
// Frame controller for the 8-tap circular convolution engine: loads x/h serially,
// holds them stable for the engine, then streams the 2N results out one per handshake.
module conv_frame_sequencer #(
  parameter int unsigned N           = 8,
  parameter int unsigned DW          = 4,
  parameter int unsigned CALC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic [N*DW-1:0]   x_bus,
  output logic [N*DW-1:0]   h_bus,
  input  logic [2*N*DW-1:0] y_bus,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [3:0]        out_index,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned CW = 5;
  localparam int unsigned IW = 4;
  localparam int unsigned XW = N * DW;
  localparam int unsigned YW = 2 * N * DW;
  localparam logic [CW-1:0] LAST_IN     = CW'(2 * N - 1);
  localparam logic [CW-1:0] LAST_SETTLE = CW'(CALC_CYCLES - 1);
  localparam logic [IW-1:0] LAST_OUT    = IW'(2 * N - 1);

  typedef enum logic [1:0] {LOAD, SETTLE, DRAIN} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [XW-1:0]   x_n, h_n;
  logic [YW-1:0]   res_q, res_n;
  logic            ov_n, ol_n, busy_n, fd_n;
  logic [DW-1:0]   od_n;
  logic [IW-1:0]   oi_n, idx_inc;

  // Input acceptance is a pure state decode so upstream never sees a valid->ready path.
  assign in_ready = (state == LOAD);
  assign idx_inc  = out_index + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      cnt        <= '0;
      x_bus      <= '0;
      h_bus      <= '0;
      res_q      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      x_bus      <= x_n;
      h_bus      <= h_n;
      res_q      <= res_n;
      out_valid  <= ov_n;
      out_data   <= od_n;
      out_index  <= oi_n;
      out_last   <= ol_n;
      busy       <= busy_n;
      frame_done <= fd_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    x_n     = x_bus;
    h_n     = h_bus;
    res_n   = res_q;
    ov_n    = out_valid;
    od_n    = out_data;
    oi_n    = out_index;
    ol_n    = out_last;
    fd_n    = 1'b0;

    unique case (state)
      LOAD: begin
        if (in_valid) begin
          for (int unsigned i = 0; i < N; i++) begin
            if (cnt == CW'(i))     x_n[i*DW +: DW] = in_data;
            if (cnt == CW'(N + i)) h_n[i*DW +: DW] = in_data;
          end
          if (cnt == LAST_IN) begin
            state_n = SETTLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      // cnt doubles as the settle timer; CALC_CYCLES must fit in CW bits.
      SETTLE: begin
        if (cnt == LAST_SETTLE) begin
          res_n   = y_bus;
          ov_n    = 1'b1;
          od_n    = y_bus[DW-1:0];
          oi_n    = '0;
          ol_n    = 1'b0;
          cnt_n   = '0;
          state_n = DRAIN;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (out_index == LAST_OUT) begin
            ov_n    = 1'b0;
            ol_n    = 1'b0;
            oi_n    = '0;
            fd_n    = 1'b1;
            state_n = LOAD;
          end else begin
            oi_n = idx_inc;
            ol_n = (idx_inc == LAST_OUT);
            for (int unsigned k = 0; k < 2 * N; k++) begin
              if (idx_inc == IW'(k)) od_n = res_q[k*DW +: DW];
            end
          end
        end
      end
      default: state_n = LOAD;
    endcase

    // Discard overrides everything, including a sample or capture on this edge.
    if (abort) begin
      state_n = LOAD;
      cnt_n   = '0;
      x_n     = x_bus;
      h_n     = h_bus;
      res_n   = res_q;
      ov_n    = 1'b0;
      ol_n    = 1'b0;
      oi_n    = '0;
      fd_n    = 1'b0;
    end

    busy_n = (state_n != LOAD);
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Scoreboard bench for conv_frame_sequencer with a behavioural convolution engine
// on y_bus; expected result streams are hand-computed constants.
module tb_conv_frame_sequencer;

  localparam int unsigned N    = 8;
  localparam int unsigned DW   = 4;
  localparam int unsigned CALC = 1;

  logic           clk = 1'b0;
  logic           rst, abort, in_valid, in_ready, out_valid, out_ready;
  logic           out_last, busy, frame_done;
  logic [DW-1:0]  in_data, out_data;
  logic [N*DW-1:0]   x_bus, h_bus;
  logic [2*N*DW-1:0] y_bus;
  logic [3:0]     out_index;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] k;
    logic       l;
  } exp_t;

  exp_t sb[$];
  int   ntotal = 0;
  int   npass  = 0;
  logic fd_pend = 1'b0;
  logic [3:0] y_c2 [16] = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0,
                             4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0};

  conv_frame_sequencer #(.N(N), .DW(DW), .CALC_CYCLES(CALC)) dut (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .x_bus(x_bus), .h_bus(h_bus), .y_bus(y_bus),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Engine model: y_k pairs tap f(k) against the circularly shifted h.
  function automatic logic [3:0] eng(input logic [31:0] xb, input logic [31:0] hb, input int k);
    int f;
    logic [3:0] acc;
    acc = 4'd0;
    f = (k < 8) ? (7 - k) : ((k - 7) % 8);
    for (int i = 0; i < 8; i++)
      acc = acc + 4'(xb[i*4 +: 4] * hb[((f - i + 8) % 8)*4 +: 4]);
    return acc;
  endfunction

  always_comb begin
    y_bus = '0;
    for (int k = 0; k < 16; k++) y_bus[k*4 +: 4] = eng(x_bus, h_bus, k);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: consumes one expected result per output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (fd_pend || frame_done) chk("frame_done", 32'(frame_done), 32'(fd_pend));
      fd_pend = 1'b0;
      if (out_valid) begin
        chk("in_ready_while_draining", 32'(in_ready), 32'd0);
        if (out_ready) begin
          if (sb.size() == 0) begin
            ntotal++;
            $display("FAIL unexpected_output: got index %0d data %0h, expected none", out_index, out_data);
          end else begin
            e = sb.pop_front();
            chk("out_data", 32'(out_data), 32'(e.d));
            chk("out_index", 32'(out_index), 32'(e.k));
            chk("out_last", 32'(out_last), 32'(e.l));
            if (e.l) fd_pend = 1'b1;
          end
        end
      end
    end
  end

  task automatic push_const(input logic [3:0] v);
    for (int k = 0; k < 16; k++) sb.push_back('{d: v, k: 4'(k), l: (k == 15)});
  endtask

  task automatic push_c2();
    for (int k = 0; k < 16; k++) sb.push_back('{d: y_c2[k], k: 4'(k), l: (k == 15)});
  endtask

  task automatic put(input logic [3:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 300) begin @(posedge clk); #1; t++; end
    if (t >= 300) chk("in_ready_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] xw, input logic [31:0] hw, input bit gap);
    for (int i = 0; i < 16; i++) begin
      if (gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      put(i < 8 ? xw[i*4 +: 4] : hw[(i-8)*4 +: 4]);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 400) begin @(posedge clk); #1; t++; end
    chk("drain_left", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_idx(input logic [3:0] k);
    int t = 0;
    while (!(out_valid && out_index == k) && t < 400) begin @(posedge clk); #1; t++; end
    chk("wait_index_timeout", 32'(t < 400), 32'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_x_bus", x_bus, 32'd0);
    chk("rst_h_bus", h_bus, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Case 1: all ones
    push_const(4'd8);
    send_frame(32'h1111_1111, 32'h1111_1111, 1'b0);
    wait_drain();

    // Case 2: impulse x, ramp h; bus slot ordering
    push_c2();
    send_frame(32'h0000_0001, 32'h7654_3210, 1'b0);
    chk("x_bus_c2", x_bus, 32'h0000_0001);
    chk("h_bus_c2", h_bus, 32'h7654_3210);
    wait_drain();

    // Case 3: all fifteens, latency from h7 accept to out_valid
    push_const(4'd8);
    send_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("settle_out_valid_low", 32'(out_valid), 32'd0);
    chk("settle_in_ready_low", 32'(in_ready), 32'd0);
    chk("settle_busy", 32'(busy), 32'd1);
    repeat (CALC - 1) begin @(posedge clk); #1; chk("settle_hold", 32'(out_valid), 32'd0); end
    @(posedge clk); #1;
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    chk("latency_out_data", 32'(out_data), 32'd8);
    wait_drain();

    // Case 4: input gaps and a three-cycle stall at k=5
    push_c2();
    send_frame(32'h0000_0001, 32'h7654_3210, 1'b1);
    wait_idx(4'd5);
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_index", 32'(out_index), 32'd5);
      chk("stall_data", 32'(out_data), 32'd2);
    end
    out_ready = 1'b1;
    wait_drain();

    // Case 5a: abort after 10 inputs; the sample alongside abort is dropped
    for (int i = 0; i < 10; i++) put(4'hF);
    abort = 1'b1; in_valid = 1'b1; in_data = 4'hF;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_load_in_ready", 32'(in_ready), 32'd1);
    chk("abort_load_busy", 32'(busy), 32'd0);
    chk("abort_load_x_bus", x_bus, 32'hFFFF_FFFF);
    chk("abort_load_h_bus", h_bus, 32'h7654_32FF);
    push_c2();
    send_frame(32'h0000_0001, 32'h7654_3210, 1'b0);
    wait_drain();

    // Case 5b: abort at k=9 of DRAIN
    push_c2();
    send_frame(32'h0000_0001, 32'h7654_3210, 1'b0);
    wait_idx(4'd9);
    out_ready = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; out_ready = 1'b1;
    chk("abort_drain_valid", 32'(out_valid), 32'd0);
    chk("abort_drain_in_ready", 32'(in_ready), 32'd1);
    chk("abort_drain_busy", 32'(busy), 32'd0);
    chk("abort_drain_index", 32'(out_index), 32'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("abort_drain_stays_idle", 32'(out_valid), 32'd0);

    // Case 5c: abort coinciding with the final sample keeps LOAD
    for (int i = 0; i < 15; i++) put(4'h1);
    abort = 1'b1; in_valid = 1'b1; in_data = 4'h1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_last_in_ready", 32'(in_ready), 32'd1);
    chk("abort_last_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_last_no_output", 32'(out_valid), 32'd0);
    push_const(4'd8);
    send_frame(32'h1111_1111, 32'h1111_1111, 1'b0);
    wait_drain();

    // Case 6: reset mid-drain, then two back-to-back frames
    push_c2();
    send_frame(32'h0000_0001, 32'h7654_3210, 1'b0);
    wait_idx(4'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    chk_reset_vals();
    chk("rst_drain_in_ready", 32'(in_ready), 32'd1);
    push_const(4'd8);
    send_frame(32'h1111_1111, 32'h1111_1111, 1'b0);
    push_c2();
    send_frame(32'h0000_0001, 32'h7654_3210, 1'b0);
    wait_drain();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
